// File: rtl/wb_trace_buffer_if.sv
// Drain port of the writeback trace buffer.
// master: rd_valid/rd_ts/rd_addr/rd_data out, rd_ready in; slave mirrors it.
interface wb_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int TS_W   = 16
);
    logic              rd_valid;
    logic              rd_ready;
    logic [TS_W-1:0]   rd_ts;
    logic [REG_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_ts,
        output rd_addr,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_ts,
        input  rd_addr,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: timestamps register-file writes into a ring buffer.
// Ports: clk, rst (async active-low), wb_en/wb_addr/wb_data tap,
// arm/disarm pulses, mode (0 stop, 1 wrap), rd drain port,
// count, overflow (sticky), state (0 idle, 1 armed, 2 stopped).
module wb_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 16,
    parameter bit FILTER_X0 = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en,
    input  logic [REG_W-1:0]       wb_addr,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   arm,
    input  logic                   disarm,
    input  logic                   mode,
    wb_trace_buffer_if.master      rd,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [1:0]             state
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_STOP  = 2'd2
    } st_e;

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    st_e             st_q;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [TS_W-1:0] ts_q;
    ent_t            mem [DEPTH];
    ent_t            head_e;

    logic valid;
    logic qual;
    logic pop;
    logic full;
    logic push;
    logic wrap;
    logic drop;
    logic start;
    logic stop;

    assign valid = (count != '0);
    assign full  = (count == (PW+1)'(DEPTH));
    assign pop   = valid && rd.rd_ready;
    assign qual  = wb_en && (st_q == S_ARMED)
                   && !(FILTER_X0 && (wb_addr == '0));

    // A full buffer with no pop either overwrites the oldest
    // entry (wrap mode) or drops the event and stops capture.
    assign push  = qual && (!full || pop || mode);
    assign wrap  = qual && full && !pop && mode;
    assign drop  = qual && full && !pop && !mode;

    // Mutually exclusive so disarm always wins over arm or a stop.
    assign start = !disarm && arm && (st_q != S_ARMED);
    assign stop  = !disarm && drop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= '{ts: ts_q, addr: wb_addr, data: wb_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= S_IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            ts_q     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop || wrap) begin
                head_q <= head_q + 1'b1;
            end
            if (push && !pop && !wrap) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (st_q == S_ARMED) begin
                ts_q <= ts_q + 1'b1;
            end
            if (drop || wrap) begin
                overflow <= 1'b1;
            end
            unique case (1'b1)
                disarm: st_q <= S_IDLE;
                start: begin
                    st_q     <= S_ARMED;
                    ts_q     <= '0;
                    overflow <= 1'b0;
                end
                stop: st_q <= S_STOP;
                default: ;
            endcase
        end
    end

    // Head outputs read as zero while the buffer is empty.
    assign head_e      = valid ? mem[head_q] : '0;
    assign rd.rd_valid = valid;
    assign rd.rd_ts    = head_e.ts;
    assign rd.rd_addr  = head_e.addr;
    assign rd.rd_data  = head_e.data;
    assign state       = st_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer.
// Scoreboard queue of expected entries, drained and compared in order.
module tb_wb_trace_buffer;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int D  = 16;
    localparam int TW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wb_en = 1'b0;
    logic arm = 1'b0;
    logic disarm = 1'b0;
    logic mode = 1'b0;
    logic [RW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic [$clog2(D):0] count;
    logic overflow;
    logic [1:0] state;

    wb_trace_buffer_if #(.DATA_W(DW), .REG_W(RW), .TS_W(TW)) rif ();

    wb_trace_buffer #(
        .DATA_W(DW), .REG_W(RW), .DEPTH(D), .TS_W(TW), .FILTER_X0(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb_en(wb_en),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .arm(arm),
        .disarm(disarm),
        .mode(mode),
        .rd(rif),
        .count(count),
        .overflow(overflow),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] ts;
        logic [RW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t exp_q[$];
    int errors = 0;
    int checks = 0;
    logic armed_m = 1'b0;
    logic [TW-1:0] ts_m = '0;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (armed_m) ts_m = ts_m + 1'b1;
    endtask

    task automatic arm_p();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        armed_m = 1'b1;
        ts_m = '0;
    endtask

    task automatic disarm_p();
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
        armed_m = 1'b0;
    endtask

    task automatic wr(input logic [RW-1:0] a, input logic [DW-1:0] d,
                      input logic rdy);
        logic popm;
        logic full_m;
        ent_t e;
        full_m = (exp_q.size() == D);
        popm = rdy && (exp_q.size() > 0);
        if (popm) begin
            checks++;
            if (rif.rd_ts !== exp_q[0].ts || rif.rd_addr !== exp_q[0].a ||
                rif.rd_data !== exp_q[0].d) begin
                errors++;
                $display("FAIL wr_pop_head: got ts=%0d x%0d %h want ts=%0d x%0d %h",
                         rif.rd_ts, rif.rd_addr, rif.rd_data,
                         exp_q[0].ts, exp_q[0].a, exp_q[0].d);
            end
            void'(exp_q.pop_front());
        end
        wb_en = 1'b1;
        wb_addr = a;
        wb_data = d;
        rif.rd_ready = rdy;
        e.ts = ts_m;
        e.a = a;
        e.d = d;
        if (armed_m && a != '0) begin
            if (full_m && !popm) begin
                if (mode) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back(e);
                end else begin
                    armed_m = 1'b0;
                end
            end else begin
                exp_q.push_back(e);
            end
        end
        cyc();
        wb_en = 1'b0;
        rif.rd_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 64) begin
            checks++;
            if (rif.rd_valid !== 1'b1 || rif.rd_ts !== exp_q[0].ts ||
                rif.rd_addr !== exp_q[0].a || rif.rd_data !== exp_q[0].d) begin
                errors++;
                $display("FAIL %s_drain[%0d]: got v=%b ts=%0d x%0d %h want v=1 ts=%0d x%0d %h",
                         tag, n, rif.rd_valid, rif.rd_ts, rif.rd_addr, rif.rd_data,
                         exp_q[0].ts, exp_q[0].a, exp_q[0].d);
            end
            rif.rd_ready = 1'b1;
            cyc();
            rif.rd_ready = 1'b0;
            void'(exp_q.pop_front());
            n++;
        end
        checks++;
        if (rif.rd_valid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL %s_empty: got v=%b count=%0d want v=0 count=0",
                     tag, rif.rd_valid, count);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (count !== '0 || state !== 2'd0 || overflow !== 1'b0 ||
            rif.rd_valid !== 1'b0 || rif.rd_ts !== '0 ||
            rif.rd_addr !== '0 || rif.rd_data !== '0) begin
            errors++;
            $display("FAIL reset: got count=%0d st=%0d ovf=%b v=%b ts=%0d a=%0d d=%h want all 0",
                     count, state, overflow, rif.rd_valid,
                     rif.rd_ts, rif.rd_addr, rif.rd_data);
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        arm_p();
        wr(5'd1, 32'h11, 1'b0);
        wr(5'd2, 32'h22, 1'b0);
        wr(5'd3, 32'h33, 1'b0);
        checks++;
        if (count !== 3 || state !== 2'd1) begin
            errors++;
            $display("FAIL basic_count: got count=%0d st=%0d want 3 1", count, state);
        end
        drain("basic");
    endtask

    task automatic test_filter();
        disarm_p();
        arm_p();
        wr(5'd0, 32'hDEAD, 1'b0);
        wr(5'd5, 32'h55, 1'b0);
        checks++;
        if (count !== 1) begin
            errors++;
            $display("FAIL filter_count: got %0d want 1", count);
        end
        drain("filter");
    endtask

    task automatic test_stop();
        disarm_p();
        mode = 1'b0;
        arm_p();
        for (int i = 1; i <= 17; i++) wr(RW'(i), 32'h100 * i, 1'b0);
        checks++;
        if (count !== 16 || state !== 2'd2 || overflow !== 1'b1 ||
            rif.rd_addr !== 5'd1) begin
            errors++;
            $display("FAIL stop_full: got count=%0d st=%0d ovf=%b head=x%0d want 16 2 1 x1",
                     count, state, overflow, rif.rd_addr);
        end
        drain("stop");
    endtask

    task automatic test_wrap();
        disarm_p();
        mode = 1'b1;
        arm_p();
        for (int i = 1; i <= 20; i++) wr(RW'(i), 32'hA000 + i, 1'b0);
        checks++;
        if (count !== 16 || state !== 2'd1 || overflow !== 1'b1 ||
            rif.rd_addr !== 5'd5) begin
            errors++;
            $display("FAIL wrap_full: got count=%0d st=%0d ovf=%b head=x%0d want 16 1 1 x5",
                     count, state, overflow, rif.rd_addr);
        end
        disarm_p();
        mode = 1'b0;
        drain("wrap");
    endtask

    task automatic test_full_push_pop();
        arm_p();
        for (int i = 1; i <= 16; i++) wr(RW'(i), 32'hB000 + i, 1'b0);
        checks++;
        if (count !== 16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_fill: got count=%0d ovf=%b want 16 0", count, overflow);
        end
        wr(5'd17, 32'h1700, 1'b1);
        checks++;
        if (count !== 16 || overflow !== 1'b0 || state !== 2'd1) begin
            errors++;
            $display("FAIL fpp_pushpop: got count=%0d ovf=%b st=%0d want 16 0 1",
                     count, overflow, state);
        end
        drain("fpp");
    endtask

    task automatic test_async_reset();
        disarm_p();
        arm_p();
        for (int i = 1; i <= 7; i++) wr(RW'(i), 32'hC000 + i, 1'b0);
        checks++;
        if (count !== 7) begin
            errors++;
            $display("FAIL areset_pre: got count=%0d want 7", count);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (count !== '0 || state !== 2'd0 || rif.rd_valid !== 1'b0 ||
            overflow !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: got count=%0d st=%0d v=%b ovf=%b want 0 0 0 0",
                     count, state, rif.rd_valid, overflow);
        end
        exp_q.delete();
        armed_m = 1'b0;
        #2;
        rst = 1'b1;
        cyc();
        wr(5'd9, 32'h99, 1'b0);
        cyc();
        checks++;
        if (count !== '0 || rif.rd_valid !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL areset_noarm: got count=%0d v=%b st=%0d want 0 0 0",
                     count, rif.rd_valid, state);
        end
    endtask

    initial begin
        rif.rd_ready = 1'b0;
        test_reset();
        test_basic();
        test_filter();
        test_stop();
        test_wrap();
        test_full_push_pop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
